// File: rtl/add_acc_pipe.sv
`timescale 1ns/1ps
// add_acc_pipe: two-stage adder/accumulator with valid/ready on both sides.
// Stage 1 captures operands and mode; stage 2 computes and holds the result.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. A valid beat is never withdrawn or changed until
// it is taken; ready may depend combinationally on the downstream ready.
module add_acc_pipe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_mode,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf
);

  // Two guard bits above the accumulator hold any acc + a + b exactly.
  localparam int XW = ACC_WIDTH + 2;

  if (ACC_WIDTH < WIDTH + 1) begin : g_bad_width
    $error("add_acc_pipe: ACC_WIDTH must be at least WIDTH+1");
  end

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_a_q, s1_a_d;
  logic [WIDTH-1:0]     s1_b_q, s1_b_d;
  logic [1:0]           s1_mode_q, s1_mode_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                 out_ovf_q, out_ovf_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  logic                 accept, adv2;
  logic                 sgn_a, sgn_b;
  logic [XW-1:0]        ext_a, ext_b, ext_acc, add_x, acc_x;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH-1:0] add_wrap, add_sat, add_max, add_min;
  logic [ACC_WIDTH-1:0] acc_wrap, acc_sat, acc_max, acc_min;
  logic                 add_fits, acc_fits;
  logic [ACC_WIDTH-1:0] res_sum;
  logic                 res_ovf;

  // Stage 2 advances when it is empty or its result is being taken.
  assign adv2      = s1_valid_q && (!out_valid_q || out_ready);
  // Held low during reset so nothing is taken while the pipe is cleared.
  assign in_ready  = !rst && (!s1_valid_q || adv2);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  // Arithmetic on the stage-1 beat: wide exact sums, then wrap or clamp.
  always_comb begin
    sgn_a    = (SIGNED != 0) && s1_a_q[WIDTH-1];
    sgn_b    = (SIGNED != 0) && s1_b_q[WIDTH-1];
    ext_a    = {{(XW-WIDTH){sgn_a}}, s1_a_q};
    ext_b    = {{(XW-WIDTH){sgn_b}}, s1_b_q};
    // A clear on the same edge as an accumulate takes effect first.
    acc_base = acc_clr ? '0 : acc_q;
    ext_acc  = {{2{(SIGNED != 0) && acc_base[ACC_WIDTH-1]}}, acc_base};
    add_x    = ext_a + ext_b;
    acc_x    = ext_acc + add_x;
    add_wrap = {{(ACC_WIDTH-WIDTH){(SIGNED != 0) && add_x[WIDTH-1]}}, add_x[WIDTH-1:0]};
    acc_wrap = acc_x[ACC_WIDTH-1:0];
    if (SIGNED != 0) begin
      // Fits in N signed bits iff every bit from N-1 upward is a sign copy.
      add_fits = (add_x[XW-1:WIDTH-1] == '0) || (add_x[XW-1:WIDTH-1] == '1);
      acc_fits = (acc_x[XW-1:ACC_WIDTH-1] == '0) || (acc_x[XW-1:ACC_WIDTH-1] == '1);
      add_max  = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
      add_min  = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
      acc_max  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      acc_min  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end else begin
      add_fits = (add_x[XW-1:WIDTH] == '0);
      acc_fits = (acc_x[XW-1:ACC_WIDTH] == '0);
      add_max  = {{(ACC_WIDTH-WIDTH){1'b0}}, {WIDTH{1'b1}}};
      add_min  = '0;
      acc_max  = '1;
      acc_min  = '0;
    end
    // The top guard bit is the sign of the exact sum and picks the rail.
    add_sat = add_fits ? add_wrap : (add_x[XW-1] ? add_min : add_max);
    acc_sat = acc_fits ? acc_wrap : (acc_x[XW-1] ? acc_min : acc_max);
    res_sum = add_wrap;
    res_ovf = !add_fits;
    case (s1_mode_q)
      2'b00: begin res_sum = add_wrap; res_ovf = !add_fits; end
      2'b01: begin res_sum = add_sat;  res_ovf = !add_fits; end
      2'b10: begin res_sum = acc_wrap; res_ovf = !acc_fits; end
      2'b11: begin res_sum = acc_sat;  res_ovf = !acc_fits; end
      default: begin res_sum = add_wrap; res_ovf = !add_fits; end
    endcase
  end

  // Next-state for both pipeline stages and the accumulator.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_mode_d  = in_mode;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end
    if (adv2) begin
      out_valid_d = 1'b1;
      out_sum_d   = res_sum;
      out_ovf_d   = res_ovf;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (acc_clr) begin
      acc_d = '0;
    end
    if (adv2 && s1_mode_q[1]) begin
      acc_d = res_sum;
    end
  end

  // State registers; reset empties the pipe and zeroes the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= 2'b00;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_add_acc_pipe.sv
`timescale 1ns/1ps
// Bench for add_acc_pipe: an unsigned and a signed instance run in lockstep
// on the same stimulus, each with its own expected-result queue.
module tb_add_acc_pipe;
  localparam int W  = 8;
  localparam int AW = 16;

  logic          clk, rst;
  logic          in_valid, acc_clr, out_ready;
  logic [W-1:0]  in_a, in_b;
  logic [1:0]    in_mode;
  logic          in_ready_u, in_ready_s;
  logic          out_valid_u, out_valid_s;
  logic [AW-1:0] out_sum_u, out_sum_s;
  logic          out_ovf_u, out_ovf_s;

  int            checks, errors;
  int            acc_u, acc_s;
  int            k;
  logic [AW:0]   exp_u_q[$];
  logic [AW:0]   exp_s_q[$];
  logic [AW:0]   last_u;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   mode;
    logic [AW:0]  exp_u;  // {ovf, sum} for SIGNED=0
    logic [AW:0]  exp_s;  // {ovf, sum} for SIGNED=1
  } vec_t;
  vec_t vecs[13];

  logic [W-1:0] bp_a[3];
  logic [W-1:0] bp_b[3];
  logic [1:0]   bp_m[3];

  add_acc_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .acc_clr(acc_clr),
    .out_valid(out_valid_u), .out_ready(out_ready),
    .out_sum(out_sum_u), .out_ovf(out_ovf_u)
  );

  add_acc_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .SIGNED(1)) u_sdut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .acc_clr(acc_clr),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_ovf(out_ovf_s)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Integer reference: {ovf, sum} for one beat, updating the model accumulator.
  task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] mode, input bit sgn, input bit clr_first,
                            inout int acc, output logic [AW:0] res);
    int va, vb, s, lo, hi, r;
    bit ovf;
    if (clr_first) acc = 0;
    va = sgn ? int'($signed(a)) : int'(a);
    vb = sgn ? int'($signed(b)) : int'(b);
    if (!mode[1]) begin
      lo = sgn ? -128 : 0;
      hi = sgn ? 127 : 255;
      s  = va + vb;
    end else begin
      lo = sgn ? -32768 : 0;
      hi = sgn ? 32767 : 65535;
      s  = acc + va + vb;
    end
    ovf = (s < lo) || (s > hi);
    if (mode[0]) begin
      r = (s < lo) ? lo : ((s > hi) ? hi : s);
    end else begin
      r = s;
      if (r > hi) r = r - (hi - lo + 1);
      if (r < lo) r = r + (hi - lo + 1);
    end
    if (mode[1]) acc = r;
    res = {ovf, r[15:0]};
  endtask

  // Scoreboard: compare every consumed result against the queue heads.
  always @(negedge clk) begin
    if (!rst && out_valid_u && out_ready) begin
      if (exp_u_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unsigned unexpected result: got %0h expected none", {out_ovf_u, out_sum_u});
      end else begin
        last_u = {out_ovf_u, out_sum_u};
        check("unsigned result {ovf,sum}", {15'b0, out_ovf_u, out_sum_u}, {15'b0, exp_u_q.pop_front()});
      end
    end
    if (!rst && out_valid_s && out_ready) begin
      if (exp_s_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL signed unexpected result: got %0h expected none", {out_ovf_s, out_sum_s});
      end else begin
        check("signed result {ovf,sum}", {15'b0, out_ovf_s, out_sum_s}, {15'b0, exp_s_q.pop_front()});
      end
    end
  end

  // Driver tasks: entered and left just after a rising edge.
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] mode, input logic [AW:0] eu, input logic [AW:0] es);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    @(negedge clk);
    while (!in_ready_u && waited < 100) begin
      waited++;
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    if (!in_ready_u) begin
      checks++; errors++;
      $display("FAIL accept timeout: in_ready=%0b expected 1 within 100 cycles", in_ready_u);
    end else begin
      exp_u_q.push_back(eu);
      exp_s_q.push_back(es);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] mode, input bit clr_first);
    logic [AW:0] eu, es;
    model_beat(a, b, mode, 1'b0, clr_first, acc_u, eu);
    model_beat(a, b, mode, 1'b1, clr_first, acc_s, es);
    drive_beat(a, b, mode, eu, es);
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    acc_u = 0;
    acc_s = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((exp_u_q.size() != 0 || exp_s_q.size() != 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (exp_u_q.size() != 0 || exp_s_q.size() != 0) begin
      errors++;
      $display("FAIL drain: outstanding %0d/%0d results, expected 0/0", exp_u_q.size(), exp_s_q.size());
      exp_u_q.delete();
      exp_s_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic bp_step();
    logic [AW:0] eu, es;
    if (k < 3) begin
      in_valid = 1'b1;
      in_a     = bp_a[k];
      in_b     = bp_b[k];
      in_mode  = bp_m[k];
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    if (in_valid && in_ready_u) begin
      model_beat(bp_a[k], bp_b[k], bp_m[k], 1'b0, 1'b0, acc_u, eu);
      model_beat(bp_a[k], bp_b[k], bp_m[k], 1'b1, 1'b0, acc_s, es);
      exp_u_q.push_back(eu);
      exp_s_q.push_back(es);
      k++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 2'b00;
    acc_clr = 1'b0; out_ready = 1'b1;
    checks = 0; errors = 0; acc_u = 0; acc_s = 0; k = 0; last_u = '0;

    //          a      b      mode   unsigned {ovf,sum}   signed {ovf,sum}
    vecs[0]  = '{8'hC8, 8'h64, 2'b00, {1'b1, 16'h002C}, {1'b0, 16'h002C}};
    vecs[1]  = '{8'h0A, 8'h14, 2'b00, {1'b0, 16'h001E}, {1'b0, 16'h001E}};
    vecs[2]  = '{8'hC8, 8'h64, 2'b01, {1'b1, 16'h00FF}, {1'b0, 16'h002C}};
    vecs[3]  = '{8'h64, 8'h64, 2'b01, {1'b0, 16'h00C8}, {1'b1, 16'h007F}};
    vecs[4]  = '{8'h9C, 8'h9C, 2'b01, {1'b1, 16'h00FF}, {1'b1, 16'hFF80}};
    vecs[5]  = '{8'h7F, 8'h01, 2'b00, {1'b0, 16'h0080}, {1'b1, 16'hFF80}};
    vecs[6]  = '{8'h80, 8'h80, 2'b00, {1'b1, 16'h0000}, {1'b1, 16'h0000}};
    vecs[7]  = '{8'hFF, 8'h01, 2'b01, {1'b1, 16'h00FF}, {1'b0, 16'h0000}};
    vecs[8]  = '{8'h64, 8'h32, 2'b10, {1'b0, 16'h0096}, {1'b0, 16'h0096}};
    vecs[9]  = '{8'hC8, 8'h01, 2'b10, {1'b0, 16'h015F}, {1'b0, 16'h005F}};
    vecs[10] = '{8'hFF, 8'hFF, 2'b11, {1'b0, 16'h035D}, {1'b0, 16'h005D}};
    vecs[11] = '{8'h01, 8'h01, 2'b00, {1'b0, 16'h0002}, {1'b0, 16'h0002}};
    vecs[12] = '{8'h00, 8'h00, 2'b10, {1'b0, 16'h035D}, {1'b0, 16'h005D}};

    bp_a[0] = 8'd10;  bp_b[0] = 8'd20; bp_m[0] = 2'b00;
    bp_a[1] = 8'd7;   bp_b[1] = 8'd8;  bp_m[1] = 2'b10;
    bp_a[2] = 8'd250; bp_b[2] = 8'd9;  bp_m[2] = 2'b01;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("reset out_valid", {31'b0, out_valid_u}, 32'd0);
    check("reset out_sum", {16'b0, out_sum_u}, 32'd0);
    check("reset out_ovf", {31'b0, out_ovf_u}, 32'd0);
    check("reset in_ready", {31'b0, in_ready_u}, 32'd0);
    check("reset signed out_valid", {31'b0, out_valid_s}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset release", {31'b0, in_ready_u}, 32'd1);
    @(posedge clk); #1;

    // Vector table, back-to-back with mode changes and no bubbles
    for (int i = 0; i < 13; i++) begin
      drive_beat(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp_u, vecs[i].exp_s);
    end
    drain();
    clear_acc();

    // Latency: result valid two edges after acceptance
    send(8'd1, 8'd2, 2'b00, 1'b0);
    @(negedge clk);
    check("latency out_valid one edge after accept", {31'b0, out_valid_u}, 32'd0);
    @(negedge clk);
    check("latency out_valid two edges after accept", {31'b0, out_valid_u}, 32'd1);
    @(posedge clk); #1;
    drain();

    // acc_clr on the same edge as an accumulate advance: clear first
    send(8'd3, 8'd4, 2'b10, 1'b0);
    send(8'd5, 8'd5, 2'b10, 1'b1);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    drain();

    // Accumulator saturation and wrap at the ACC_WIDTH boundary
    clear_acc();
    for (int i = 0; i < 129; i++) send(8'hFF, 8'hFF, 2'b11, 1'b0);
    drain();
    check("acc_sat beat 129 clamps", {15'b0, last_u}, {15'b0, 1'b1, 16'hFFFF});
    clear_acc();
    for (int i = 0; i < 129; i++) send(8'hFF, 8'hFF, 2'b10, 1'b0);
    drain();
    check("acc beat 129 wraps", {15'b0, last_u}, {15'b0, 1'b1, 16'h00FE});

    // Backpressure: 3 beats offered while the output stalls for 5 cycles
    out_ready = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 5; cyc++) bp_step();
    check("beats accepted under stall", k, 32'd2);
    @(negedge clk);
    check("in_ready low under stall", {31'b0, in_ready_u}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && k < 3; cyc++) bp_step();
    in_valid = 1'b0;
    check("beats accepted after release", k, 32'd3);
    drain();

    // Random mixed traffic with random output stalls
    clear_acc();
    for (int i = 0; i < 60; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)), 1'b0);
    end
    drain();

    // Reset pulsed between edges with two beats in flight
    out_ready = 1'b0;
    send(8'd30, 8'd40, 2'b10, 1'b0);
    send(8'd5, 8'd6, 2'b10, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid reset out_valid", {31'b0, out_valid_u}, 32'd0);
    check("mid reset out_sum", {16'b0, out_sum_u}, 32'd0);
    check("mid reset out_ovf", {31'b0, out_ovf_u}, 32'd0);
    check("mid reset in_ready", {31'b0, in_ready_u}, 32'd0);
    check("mid reset signed out_valid", {31'b0, out_valid_s}, 32'd0);
    exp_u_q.delete();
    exp_s_q.delete();
    acc_u = 0;
    acc_s = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready after mid reset", {31'b0, in_ready_u}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'd1, 8'd2, 2'b10, 1'b0);
    drain();
    check("first acc after reset", {15'b0, last_u}, {15'b0, 1'b0, 16'h0003});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
